// File: rtl/cacheline_adaptor.sv
// Adapts 256-bit cache line reads/writes to four 64-bit memory bursts.
// Define CACHELINE_ADAPTOR_PERF_EN to enable the completed-line counters.
module cacheline_adaptor #(
    parameter int unsigned s_offset = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    output logic         resp_o,
    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i,
    output logic [31:0]  rd_lines_o,
    output logic [31:0]  wr_lines_o
);

    localparam logic [31:0] AddrMask = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {StIdle, StRdBurst, StWrBurst, StDone} state_e;

    state_e       state_q, state_d;
    logic [1:0]   count_q, count_d;
    logic [31:0]  addr_q, addr_d;
    logic [255:0] rline_q, rline_d;
    logic [255:0] wline_q, wline_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= 2'd0;
            addr_q  <= 32'd0;
            rline_q <= 256'd0;
            wline_q <= 256'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            rline_q <= rline_d;
            wline_q <= wline_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        rline_d = rline_q;
        wline_d = wline_q;
        unique case (state_q)
            StIdle: begin
                // Write takes priority when both requests are raised together.
                if (write_i) begin
                    state_d = StWrBurst;
                    addr_d  = address_i & AddrMask;
                    wline_d = line_i;
                    count_d = 2'd0;
                end else if (read_i) begin
                    state_d = StRdBurst;
                    addr_d  = address_i & AddrMask;
                    count_d = 2'd0;
                end
            end
            StRdBurst: begin
                if (resp_i) begin
                    rline_d[{count_q, 6'd0} +: 64] = burst_i;
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd3) state_d = StDone;
                end
            end
            StWrBurst: begin
                if (resp_i) begin
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd3) state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign address_o = addr_q;
    assign line_o    = rline_q;
    assign read_o    = (state_q == StRdBurst);
    assign write_o   = (state_q == StWrBurst);
    assign resp_o    = (state_q == StDone);
    assign burst_o   = (state_q == StWrBurst) ? wline_q[{count_q, 6'd0} +: 64] : 64'd0;

`ifdef CACHELINE_ADAPTOR_PERF_EN
    logic        is_wr_q;
    logic [31:0] rd_lines_q, wr_lines_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            is_wr_q    <= 1'b0;
            rd_lines_q <= 32'd0;
            wr_lines_q <= 32'd0;
        end else begin
            // Direction is captured on the IDLE exit edge and held through DONE.
            if (state_q == StIdle) is_wr_q <= write_i;
            if (state_q == StDone) begin
                if (is_wr_q) wr_lines_q <= wr_lines_q + 32'd1;
                else         rd_lines_q <= rd_lines_q + 32'd1;
            end
        end
    end

    assign rd_lines_o = rd_lines_q;
    assign wr_lines_o = wr_lines_q;
`else
    assign rd_lines_o = 32'd0;
    assign wr_lines_o = 32'd0;
`endif

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter s_offset, default 5, giving log2 of line bytes; address_o low s_offset bits are forced to 0.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port line_i  input  256  cache line to write back, from the cache.
REQ-005 SHALL have port line_o  output  256  cache line filled from memory, to the cache.
REQ-006 SHALL have port address_i  input  32  cache request byte address.
REQ-007 SHALL have port read_i / write_i  input  1 each  cache line read and line write requests.
REQ-008 SHALL have port resp_o  output  1  one-cycle completion pulse to the cache.
REQ-009 SHALL have port burst_i  input  64  read beat from memory.
REQ-010 SHALL have port burst_o  output  64  write beat to memory.
REQ-011 SHALL have port address_o  output  32  line-aligned memory address.
REQ-012 SHALL have port read_o / write_o  output  1 each  memory burst read and burst write requests.
REQ-013 SHALL have port resp_i  input  1  memory beat strobe; high once per transferred beat.
REQ-014 SHALL have ports rd_lines_o / wr_lines_o  output  32 each  completed read and write line counters.

Function
REQ-015 SHALL implement the FSM states IDLE, RD_BURST, WR_BURST and DONE, with a 2-bit beat counter.
REQ-016 In IDLE, SHALL go to WR_BURST if write_i=1, otherwise to RD_BURST if read_i=1; write wins when both are high.
REQ-017 On leaving IDLE, SHALL latch address_i[31:s_offset] into the address register (low bits 0), latch line_i on a write, and clear the beat counter.
REQ-018 address_o SHALL come from the latched register, with no combinational path from address_i.
REQ-019 read_o SHALL equal (state==RD_BURST); write_o SHALL equal (state==WR_BURST); both are decoded from registered state.
REQ-020 Beat order: beat k maps to line bits [64k+63:64k], k=0..3, with beat 0 first.
REQ-021 In RD_BURST, each cycle with resp_i=1 SHALL store burst_i into beat[count] and increment count.
REQ-022 In WR_BURST, burst_o SHALL equal latched beat[count]; each resp_i=1 cycle SHALL increment count.
REQ-023 A resp_i=1 cycle at count=3 SHALL move the FSM to DONE, and the counter SHALL wrap to 0.
REQ-024 DONE SHALL last exactly one cycle with resp_o=1, then return to IDLE.
REQ-025 Latency: if the 4th beat is strobed in cycle N, resp_o SHALL be high in N+1 and the FSM SHALL be in IDLE in N+2.
REQ-026 Request latency: a request first seen in IDLE at cycle 0 SHALL raise read_o/write_o in cycle 1.
REQ-027 line_o SHALL be valid in the resp_o cycle and SHALL hold until the next read's first beat; writes SHALL NOT alter line_o.
REQ-028 Changes to address_i, line_i, read_i or write_i while not in IDLE SHALL be ignored.
REQ-029 resp_i while in IDLE or DONE SHALL be ignored; counters and data SHALL be unchanged.
REQ-030 resp_i gaps mid-burst SHALL stall the burst: the count holds and read_o/write_o stay high.
REQ-031 burst_o SHALL be 0 outside WR_BURST.

Reset
REQ-032 rst=1 at any edge SHALL force IDLE with count=0; this includes aborting a burst mid-transfer.
REQ-033 After reset, read_o, write_o and resp_o SHALL be 0 in the following cycle.
REQ-034 After reset, address_o, burst_o and line_o SHALL reset to 0.
REQ-035 rd_lines_o and wr_lines_o SHALL reset to 0.
REQ-036 An aborted burst SHALL produce no resp_o and no counter increment.

Configuration
REQ-037 With macro CACHELINE_ADAPTOR_PERF_EN defined, rd_lines_o/wr_lines_o SHALL increment by 1 in the cycle resp_o is high for a read/write, wrapping modulo 2^32.
REQ-038 Without CACHELINE_ADAPTOR_PERF_EN, rd_lines_o and wr_lines_o SHALL be tied to 0, no counter flops SHALL be synthesized, and all other behaviour SHALL be identical.

Verification
REQ-039 Read: address_i=0x0000_1234, read_i=1; memory strobes beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> address_o=0x0000_1220, line_o={0x44..44,0x33..33,0x22..22,0x11..11}, single resp_o pulse one cycle after beat 4.
REQ-040 Write: line_i={0xD..,0xC..,0xB..,0xA..}, write_i=1, address_i=0x8000_003F -> address_o=0x8000_0020, burst_o=0xA..,0xB..,0xC..,0xD.. in order, write_o deasserts after the 4th resp_i.
REQ-041 Gapped read: resp_i pattern 1,0,0,1,1,0,1 -> read_o stays high throughout, data is correct, resp_o comes one cycle after the final strobe.
REQ-042 Simultaneous read_i=write_i=1 in IDLE -> write_o=1 and read_o=0; read_i held through the resp_o cycle -> a single transaction only.
REQ-043 rst=1 after beat 2 of a read -> next cycle read_o=0 and resp_o=0; a following fresh read completes normally with line_o matching new data.
REQ-044 With CACHELINE_ADAPTOR_PERF_EN: 3 reads + 2 writes -> rd_lines_o=3, wr_lines_o=2; without the macro -> both stay 0.
